// File: rtl/esfa_trace_recorder.sv
// esfa_trace_recorder: records ESFA operations as 40-bit program words into a RAM write port, closed by a terminator
//   clk, reset                    clock, asynchronous active-high reset
//   start, finish                 open a recording (IDLE/DONE), close it (RECORD)
//   in_valid/in_ready + in_*      capture handshake and operation fields
//   mem_we/mem_ready/mem_addr/    registered RAM write request, held until granted
//   mem_wdata
//   busy, done, overflow,         status; overflow is sticky until the next accepted start
//   word_count                    words written including the terminator
module esfa_trace_recorder #(
   parameter int ADDR_W     = 8,
   parameter int MEM_DEPTH  = 256,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              finish,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_is_mutating,
   input  logic              in_is_metadata,
   input  logic [7:0]        in_new_index,
   input  logic [7:0]        in_new_value,
   input  logic [7:0]        in_metadata,
   input  logic [7:0]        in_selector,
   input  logic              in_result_bool,
   output logic              mem_we,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [39:0]       mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [ADDR_W:0]   word_count
);
   localparam int FW = $clog2(FIFO_DEPTH);
   // one slot is always kept back for the terminator
   localparam logic [ADDR_W:0] CAP = (ADDR_W+1)'(MEM_DEPTH - 1);
   localparam logic [39:0] TERM_WORD = 40'h00_0000_0004;
   typedef enum logic [2:0] {S_IDLE, S_RECORD, S_DRAIN, S_TERM, S_DONE} state_t;
   state_t state_q, state_d;
   logic [FW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [39:0] fifo_mem_q [FIFO_DEPTH];
   logic [ADDR_W:0] acc_q, acc_d, cnt_q, cnt_d;
   logic mem_we_q, mem_we_d, ovf_q, ovf_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [39:0] mem_wdata_q, mem_wdata_d, in_word;
   logic fifo_empty, fifo_full, cap_left, push, pop, wr_done;
   assign fifo_empty = wr_ptr_q == rd_ptr_q;
   assign fifo_full  = (wr_ptr_q[FW] != rd_ptr_q[FW]) && (wr_ptr_q[FW-1:0] == rd_ptr_q[FW-1:0]);
   assign cap_left   = acc_q < CAP;
   assign in_ready   = state_q == S_RECORD && !fifo_full && cap_left && !finish;
   assign push       = in_valid && in_ready;
   assign wr_done    = mem_we_q && mem_ready;
   // a new word may be popped in the same cycle the held one is granted
   assign pop        = (state_q == S_RECORD || state_q == S_DRAIN) && !fifo_empty && (!mem_we_q || mem_ready);
   assign in_word    = {in_selector, in_metadata, in_new_value, in_new_index, 4'h0, in_is_metadata, 1'b0,
                        in_is_mutating ? 1'b0 : in_result_bool, in_is_mutating};
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q + (FW+1)'(push);
      rd_ptr_d    = rd_ptr_q + (FW+1)'(pop);
      acc_d       = acc_q + (ADDR_W+1)'(push);
      cnt_d       = cnt_q + (ADDR_W+1)'(wr_done);
      ovf_d       = ovf_q || (state_q == S_RECORD && in_valid && !cap_left);
      mem_we_d    = mem_we_q && !mem_ready;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if (pop) begin
         mem_we_d    = 1'b1;
         mem_addr_d  = cnt_d[ADDR_W-1:0];
         mem_wdata_d = fifo_mem_q[rd_ptr_q[FW-1:0]];
      end
      case (state_q)
         S_IDLE, S_DONE: if (start) begin
            state_d  = S_RECORD;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            acc_d    = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
         end
         S_RECORD: state_d = finish ? S_DRAIN : S_RECORD;
         S_DRAIN:  state_d = (fifo_empty && !mem_we_q) ? S_TERM : S_DRAIN;
         S_TERM: if (!mem_we_q) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = cnt_q[ADDR_W-1:0];
            mem_wdata_d = TERM_WORD;
         end else if (mem_ready) begin
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   always_ff @(posedge clk)
      if (push) fifo_mem_q[wr_ptr_q[FW-1:0]] <= in_word;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign busy       = state_q == S_RECORD || state_q == S_DRAIN || state_q == S_TERM;
   assign done       = state_q == S_DONE;
   assign overflow   = ovf_q;
   assign word_count = cnt_q;
endmodule
